// File: rtl/regfile_wb_scheduler.sv
// regfile_wb_scheduler
//   Sits in front of the single-write-port register file. It arbitrates the
//   write port between the ALU and LSU writeback requesters (round-robin,
//   valid/ready). It also keeps a per-register busy scoreboard, which stalls
//   issue on RAW and WAW hazards against writes that are still in flight.
//
// Ports
//   clk, rst                 clock; asynchronous active-high reset
//   issue_*                  decode-side instruction (sources, destination, valid)
//   issue_stall              instruction not accepted this cycle (combinational)
//   alu_wb_* / lsu_wb_*      writeback requests (valid, rd, data) and ready (comb.)
//   rf_wr_en/rf_regW/rf_portW registered register-file write port
//   busy_vec                 scoreboard state; bit 0 always 0
module regfile_wb_scheduler #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 32,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_valid,
  input  logic [AW-1:0]    issue_rs1,
  input  logic [AW-1:0]    issue_rs2,
  input  logic             issue_use_rs1,
  input  logic             issue_use_rs2,
  input  logic [AW-1:0]    issue_rd,
  input  logic             issue_rd_we,
  output logic             issue_stall,
  input  logic             alu_wb_valid,
  input  logic [AW-1:0]    alu_wb_rd,
  input  logic [WIDTH-1:0] alu_wb_data,
  output logic             alu_wb_ready,
  input  logic             lsu_wb_valid,
  input  logic [AW-1:0]    lsu_wb_rd,
  input  logic [WIDTH-1:0] lsu_wb_data,
  output logic             lsu_wb_ready,
  output logic             rf_wr_en,
  output logic [AW-1:0]    rf_regW,
  output logic [WIDTH-1:0] rf_portW,
  output logic [DEPTH-1:0] busy_vec
);

  typedef enum logic {SRC_ALU = 1'b0, SRC_LSU = 1'b1} src_e;

  src_e             last_q, last_d;
  logic [DEPTH-1:0] busy_q, busy_d;
  logic             wr_en_q, wr_en_d;
  logic [AW-1:0]    regw_q, regw_d;
  logic [WIDTH-1:0] portw_q, portw_d;
  logic             issue_ok;

  // Hazard check and arbitration are purely combinational on registered state.
  always_comb begin
    issue_stall  = issue_valid & ((issue_use_rs1 & busy_q[issue_rs1]) |
                                  (issue_use_rs2 & busy_q[issue_rs2]) |
                                  (issue_rd_we   & busy_q[issue_rd]));
    issue_ok     = issue_valid & ~issue_stall;
    // On a tie the requester that did not win last time is granted.
    alu_wb_ready = alu_wb_valid & (~lsu_wb_valid | (last_q == SRC_LSU));
    lsu_wb_ready = lsu_wb_valid & (~alu_wb_valid | (last_q == SRC_ALU));
  end

  always_comb begin
    last_d  = last_q;
    wr_en_d = 1'b0;
    regw_d  = '0;
    portw_d = '0;
    if (alu_wb_ready) begin
      last_d  = SRC_ALU;
      wr_en_d = (alu_wb_rd != '0);   // x0 writes are consumed but dropped
      regw_d  = alu_wb_rd;
      portw_d = alu_wb_data;
    end else if (lsu_wb_ready) begin
      last_d  = SRC_LSU;
      wr_en_d = (lsu_wb_rd != '0);
      regw_d  = lsu_wb_rd;
      portw_d = lsu_wb_data;
    end
  end

  // Busy clears on the same edge the register file captures the data, so a
  // dependent instruction released by the clear always reads the new value.
  // Set is applied after clear so it wins on the (illegal) coincidence.
  always_comb begin
    busy_d = busy_q;
    if (wr_en_q) busy_d[regw_q] = 1'b0;
    if (issue_ok && issue_rd_we) busy_d[issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q  <= SRC_LSU;
      busy_q  <= '0;
      wr_en_q <= 1'b0;
      regw_q  <= '0;
      portw_q <= '0;
    end else begin
      last_q  <= last_d;
      busy_q  <= busy_d;
      wr_en_q <= wr_en_d;
      regw_q  <= regw_d;
      portw_q <= portw_d;
    end
  end

  assign rf_wr_en = wr_en_q;
  assign rf_regW  = regw_q;
  assign rf_portW = portw_q;
  assign busy_vec = busy_q;

endmodule
